// File: rtl/clock_scan_ctrl.sv
// clock_scan_ctrl: mm:ss clock for four 7-segment digits (HEX3..HEX0).
//   - BCD minutes/seconds advanced by a 1 s prescaler (CLK_HZ cycles).
//   - KEY[0] run/stop, KEY[1] minute +1, KEY[2] seconds clear (active-low,
//     2-FF synchronised, falling-edge events, no debounce here).
//   - One shared seg7dec is time-shared by a round-robin scan pointer; each
//     digit owns the decoder for SCAN_DIV cycles and its pattern is registered,
//     so the HEX outputs only change on their own scan write.
// Optional build macro: CLOCK_LZ_BLANK_EN -- blank HEX3 when minutes tens is 0.

// Hex digit to active-low gfedcba segment pattern.
module seg7dec (
  input  logic [3:0] seg,
  output logic [6:0] dec
);

  // Pure lookup; 0 = segment lit.
  always_comb begin
    dec = 7'b1111111;
    case (seg)
      4'h0: dec = 7'b1000000;
      4'h1: dec = 7'b1111001;
      4'h2: dec = 7'b0100100;
      4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001;
      4'h5: dec = 7'b0010010;
      4'h6: dec = 7'b0000010;
      4'h7: dec = 7'b1111000;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0010000;
      4'hA: dec = 7'b0001000;
      4'hB: dec = 7'b0000011;
      4'hC: dec = 7'b1000110;
      4'hD: dec = 7'b0100001;
      4'hE: dec = 7'b0000110;
      4'hF: dec = 7'b0001110;
      default: dec = 7'b1111111;
    endcase
  end

endmodule

module clock_scan_ctrl #(
  parameter int CLK_HZ   = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] KEY,
  output logic       RUN,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);

  localparam int PRE_W  = $clog2(CLK_HZ);
  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(CLK_HZ - 1);
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SCAN_DIV - 1);
  localparam logic [6:0]        BLANK    = 7'b1111111;

  // Two-digit packed BCD increment that wraps 59 -> 00.
  function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) r = 8'h00;
      else                r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Button synchroniser and edge detector (all idle high).
  logic [2:0] key_s1_q, key_s1_d;
  logic [2:0] key_s2_q, key_s2_d;
  logic [2:0] key_prev_q, key_prev_d;
  logic [2:0] key_ev;

  // Timekeeping state.
  logic              run_q, run_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [7:0]        sec_q, sec_d;
  logic [7:0]        min_q, min_d;
  logic              tick;
  logic              tick_eff;
  logic              carry;

  // Scan scheduler.
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        ptr_q, ptr_d;
  logic              slot_wrap;

  // Decode pipeline: p0 = nibble mux, p1 = decoder input register.
  logic              vld_p0;
  logic [3:0]        nib_p0;
  logic              vld_p1_q, vld_p1_d;
  logic [1:0]        ptr_p1_q, ptr_p1_d;
  logic [3:0]        nib_p1_q, nib_p1_d;
  logic [6:0]        dec_p1;
  logic [6:0]        pat_p1;
  logic [3:0][6:0]   hex_q, hex_d;

  // Synchroniser chain and one-cycle falling-edge events.
  always_comb begin
    key_s1_d   = KEY;
    key_s2_d   = key_s1_q;
    key_prev_d = key_s2_q;
    key_ev     = key_prev_q & ~key_s2_q;
  end

  // Prescaler, seconds/minutes counters and run flag, including the
  // resolution of button events that land on the same cycle as a tick.
  always_comb begin
    tick     = run_q && (pre_q == PRE_MAX);
    // A seconds clear swallows a coincident tick so it can never carry.
    tick_eff = tick && !key_ev[2];

    pre_d = pre_q;
    if (key_ev[2] || tick) pre_d = '0;
    else if (run_q)        pre_d = pre_q + PRE_W'(1);

    sec_d = sec_q;
    carry = 1'b0;
    if (key_ev[2]) begin
      sec_d = 8'h00;
    end else if (tick_eff) begin
      sec_d = bcd60_inc(sec_q);
      carry = (sec_q == 8'h59);
    end

    // Carry and KEY[1] each add one, so both together add two.
    min_d = min_q;
    if (carry)     min_d = bcd60_inc(min_d);
    if (key_ev[1]) min_d = bcd60_inc(min_d);

    // The tick above is still applied in the cycle RUN toggles.
    run_d = run_q ^ key_ev[0];
  end

  // Free-running slot counter and round-robin digit pointer.
  always_comb begin
    slot_wrap = (slot_q == SLOT_MAX);
    slot_d    = slot_wrap ? '0 : slot_q + SLOT_W'(1);
    ptr_d     = slot_wrap ? ptr_q + 2'd1 : ptr_q;
  end

  // Stage p0: pick the nibble owned by the current pointer on slot entry.
  always_comb begin
    vld_p0 = (slot_q == '0);
    nib_p0 = 4'h0;
    case (ptr_q)
      2'd0: nib_p0 = sec_q[3:0];
      2'd1: nib_p0 = sec_q[7:4];
      2'd2: nib_p0 = min_q[3:0];
      2'd3: nib_p0 = min_q[7:4];
      default: nib_p0 = 4'h0;
    endcase
    vld_p1_d = vld_p0;
    ptr_p1_d = ptr_q;
    nib_p1_d = nib_p0;
  end

  seg7dec u_seg7dec (
    .seg (nib_p1_q),
    .dec (dec_p1)
  );

  // Stage p1: decoded pattern written into the one digit that owns the slot.
  always_comb begin
    pat_p1 = dec_p1;
`ifdef CLOCK_LZ_BLANK_EN
    if (ptr_p1_q == 2'd3 && nib_p1_q == 4'h0) pat_p1 = BLANK;
`endif
    hex_d = hex_q;
    if (vld_p1_q) hex_d[ptr_p1_q] = pat_p1;
  end

  // Control and time state with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      key_s1_q   <= 3'b111;
      key_s2_q   <= 3'b111;
      key_prev_q <= 3'b111;
      run_q      <= 1'b1;
      pre_q      <= '0;
      sec_q      <= 8'h00;
      min_q      <= 8'h00;
      slot_q     <= '0;
      ptr_q      <= 2'd0;
      vld_p1_q   <= 1'b0;
      hex_q      <= {4{BLANK}};
    end else begin
      key_s1_q   <= key_s1_d;
      key_s2_q   <= key_s2_d;
      key_prev_q <= key_prev_d;
      run_q      <= run_d;
      pre_q      <= pre_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      slot_q     <= slot_d;
      ptr_q      <= ptr_d;
      vld_p1_q   <= vld_p1_d;
      hex_q      <= hex_d;
    end
  end

  // Decoder input data registers; qualified by vld_p1_q so no reset needed.
  always_ff @(posedge CLK) begin
    ptr_p1_q <= ptr_p1_d;
    nib_p1_q <= nib_p1_d;
  end

  assign RUN  = run_q;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];

endmodule

// File: tb/tb_clock_scan_ctrl.sv
// Self-checking bench for clock_scan_ctrl with CLK_HZ=10, SCAN_DIV=2.
// Expected display values are queued when stimulus is applied and compared
// once the scan has had time to write them to the HEX outputs.
module tb_clock_scan_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [2:0] KEY = 3'b111;
  logic       RUN;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    int         sel;
    logic [6:0] val;
  } exp_t;

  exp_t sb_q[$];

  clock_scan_ctrl #(.CLK_HZ(10), .SCAN_DIV(2)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .KEY  (KEY),
    .RUN  (RUN),
    .HEX0 (HEX0),
    .HEX1 (HEX1),
    .HEX2 (HEX2),
    .HEX3 (HEX3)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%b want=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] hex3_exp(input int d);
`ifdef CLOCK_LZ_BLANK_EN
    if (d == 0) return 7'b1111111;
`endif
    return seg7(d);
  endfunction

  function automatic logic [6:0] obs(input int sel);
    case (sel)
      0: return HEX0;
      1: return HEX1;
      2: return HEX2;
      3: return HEX3;
      default: return {6'b0, RUN};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [6:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic push_time(input string tag, input int mm, input int ss);
    push({tag, "_h0"}, 0, seg7(ss % 10));
    push({tag, "_h1"}, 1, seg7(ss / 10));
    push({tag, "_h2"}, 2, seg7(mm % 10));
    push({tag, "_h3"}, 3, hex3_exp(mm / 10));
  endtask

  task automatic push_run(input string tag, input logic r);
    push({tag, "_run"}, 4, {6'b0, r});
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Held-low pulse of 3 CLK; the event lands on the 3rd rising edge.
  task automatic press(input int b);
    KEY[b] = 1'b0;
    cyc(3);
    KEY[b] = 1'b1;
    cyc(3);
  endtask

  initial begin
    // Reset state
    cyc(3);
    for (int i = 0; i < 4; i++) push($sformatf("rst_h%0d", i), i, 7'b1111111);
    push_run("rst", 1'b1);
    drain();

    // Release; state index k = rising edges since release.
    RST = 1'b1;
    cyc(29);                                  // k=29, time 00:02
    push_time("run20", 0, 2);
    push_run("run20", 1'b1);
    drain();

    // Stop during second 05 (event at edge 55, prescaler held at 5).
    cyc(23);                                  // k=52
    press(0);
    cyc(100);
    push_time("stop", 0, 5);
    push_run("stop", 1'b0);
    drain();

    // Resume at S0+3, stop again at S0+8 which coincides with the tick
    // (remaining prescaler count 5..9).
    KEY[0] = 1'b0; cyc(3);
    KEY[0] = 1'b1; cyc(2);
    KEY[0] = 1'b0; cyc(3);
    KEY[0] = 1'b1; cyc(3);
    cyc(12);
    push_time("tickstop", 0, 6);
    push_run("tickstop", 1'b0);
    drain();

    // Preload 59 minutes while stopped, then clear seconds.
    repeat (59) press(1);
    cyc(12);
    push_time("preload", 59, 6);
    drain();
    press(2);
    press(0);                                 // resume at R, now R+3
    cyc(596);                                 // R+599
    push_time("t5959", 59, 59);
    push_run("t5959", 1'b1);
    drain();
    cyc(11);                                  // R+610
    push_time("wrap", 0, 0);
    drain();

    // Build 12:34 and clear seconds on the 34 -> 35 tick.
    press(0);
    press(2);
    repeat (12) press(1);
    press(0);                                 // resume at R2, now R2+3
    cyc(344);                                 // R2+347
    press(2);                                 // event at R2+350 (tick)
    cyc(6);                                   // R2+359
    push_time("clr_tick", 12, 0);
    push_run("clr_tick", 1'b1);
    drain();
    cyc(10);                                  // R2+369
    push_time("clr_pre", 12, 1);
    drain();

    // Build 58:00, run to 58:59, minute +1 on the carrying tick.
    press(0);
    press(2);
    repeat (46) press(1);
    press(0);                                 // resume at R3, now R3+3
    cyc(594);                                 // R3+597
    press(1);                                 // event at R3+600 (carry tick)
    cyc(6);                                   // R3+609
    push_time("carry2", 0, 0);
    drain();

    // Build 07:42 and reset in the middle of the scan.
    press(0);
    press(2);
    repeat (7) press(1);
    press(0);                                 // resume at R4, now R4+3
    cyc(426);                                 // R4+429
    push_time("pre_rst", 7, 42);
    drain();
    RST = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) push($sformatf("arst_h%0d", i), i, 7'b1111111);
    push_run("arst", 1'b1);
    drain();
    @(negedge CLK);
    RST = 1'b1;                               // k=0
    cyc(1);
    push("rel1_h0", 0, 7'b1111111);
    drain();
    cyc(1);                                   // k=2
    push("rel2_h0", 0, seg7(0));
    push("rel2_h3", 3, 7'b1111111);
    drain();
    cyc(5);                                   // k=7
    push("rel7_h1", 1, seg7(0));
    push("rel7_h2", 2, seg7(0));
    push("rel7_h3", 3, 7'b1111111);
    drain();
    cyc(1);                                   // k=8
    push("rel8_h3", 3, hex3_exp(0));
    push_run("rel8", 1'b1);
    drain();

    // Leading-zero handling on HEX3 at 05:00 and 10:00.
    press(0);
    press(2);
    repeat (5) press(1);
    cyc(12);
    push_time("lz05", 5, 0);
    drain();
    repeat (5) press(1);
    cyc(12);
    push_time("lz10", 10, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
